// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The NOP constants describe what a flushed pipeline register holds; the
// datapath uses them when it loads a bubble into IF/ID, ID/EX or MEM/WB.
package hazard_pkg;

  // Controller state, named after the situation the pipeline is in next cycle.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FETCH_WAIT = 2'd2,
    KILL       = 2'd3
  } hz_state_e;

  // Canonical RISC-V NOP: addi x0, x0, 0.
  localparam logic [6:0]  NOP_OPCODE = 7'b0010011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // Pick the next state from the winning case's view of the next cycle.
  // A data-memory wait always dominates, then an outstanding wrong-path
  // fetch, then a fetch that has not yet returned.
  function automatic hz_state_e hz_next_state(input logic mem_wait,
                                              input logic kill_next,
                                              input logic imem_ready);
    hz_state_e nxt;
    if (mem_wait) begin
      nxt = MEM_WAIT;
    end else if (kill_next) begin
      nxt = KILL;
    end else if (!imem_ready) begin
      nxt = FETCH_WAIT;
    end else begin
      nxt = RUN;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and the
// hazard controller. The slave modport is the controller side; the master
// modport is the datapath side that produces the hazard inputs.
// HAZARD_PERF_EN adds the two performance counter outputs.
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  import hazard_pkg::*;

  logic load_use_flag;
  logic branch_taken_E;
  logic mem_op_M;
  logic dmem_ready;
  logic imem_ready;

  logic stall_F;
  logic stall_D;
  logic stall_E;
  logic stall_M;
  logic flush_D;
  logic flush_E;
  logic bubble_W;
  logic redirect_valid;
  logic imem_ack;
  logic dmem_timeout;

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] perf_stall_cycles;
  logic [CNT_WIDTH-1:0] perf_flush_count;

  modport master (
    output load_use_flag, branch_taken_E, mem_op_M, dmem_ready, imem_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
    input  redirect_valid, imem_ack, dmem_timeout,
    input  perf_stall_cycles, perf_flush_count
  );

  modport slave (
    input  load_use_flag, branch_taken_E, mem_op_M, dmem_ready, imem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
    output redirect_valid, imem_ack, dmem_timeout,
    output perf_stall_cycles, perf_flush_count
  );
`else
  modport master (
    output load_use_flag, branch_taken_E, mem_op_M, dmem_ready, imem_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
    input  redirect_valid, imem_ack, dmem_timeout
  );

  modport slave (
    input  load_use_flag, branch_taken_E, mem_op_M, dmem_ready, imem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
    output redirect_valid, imem_ack, dmem_timeout
  );
`endif

endinterface

// File: rtl/hazard_ctrl_wait_timer.sv
// Data-memory watchdog: counts consecutive wait cycles and raises a sticky
// error once the count reaches DMEM_TIMEOUT. Only reset clears the flag.
module hazard_wait_timer #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_wait,
  output logic timeout
);

  localparam int             CW    = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(DMEM_TIMEOUT);

  logic [CW-1:0] count_q, count_d;
  logic          timeout_q, timeout_d;

  // Count up while the wait persists, saturate at the limit, drop to zero on any break.
  always_comb begin
    count_d = '0;
    if (mem_wait) begin
      count_d = (count_q == LIMIT) ? count_q : count_q + CW'(1);
    end
    timeout_d = timeout_q | (count_d == LIMIT);
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core. Resolves memory waits,
// taken branches, load-use hazards and wrong-path fetch responses into
// per-stage stall/flush controls with zero-cycle latency, tracking the
// outstanding wrong-path fetch across cycles.
// Optional feature macro: HAZARD_PERF_EN (stall/flush performance counters).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_WIDTH    = 32
) (
  input logic           clk,
  input logic           rst_n,
  hazard_ctrl_if.slave  hz
);

  hz_state_e state_q, state_d;
  logic      kill_hold_q, kill_hold_d;

  logic mem_wait;
  logic kill_pend;

  logic stall_f_c, stall_d_c, stall_e_c, stall_m_c;
  logic flush_d_c, flush_e_c, bubble_w_c, redirect_c, ack_c;

  logic timeout_flag;

  assign mem_wait = hz.mem_op_M & ~hz.dmem_ready;

  // A wrong-path fetch is outstanding in KILL, or while a memory wait
  // froze the pipeline after one was already pending.
  assign kill_pend = (state_q == KILL) | ((state_q == MEM_WAIT) & kill_hold_q);

  // Resolve the highest-priority hazard into control outputs and next state.
  always_comb begin
    stall_f_c   = 1'b0;
    stall_d_c   = 1'b0;
    stall_e_c   = 1'b0;
    stall_m_c   = 1'b0;
    flush_d_c   = 1'b0;
    flush_e_c   = 1'b0;
    bubble_w_c  = 1'b0;
    redirect_c  = 1'b0;
    ack_c       = 1'b0;
    kill_hold_d = kill_pend & ~hz.imem_ready;

    if (mem_wait) begin
      stall_f_c   = 1'b1;
      stall_d_c   = 1'b1;
      stall_e_c   = 1'b1;
      stall_m_c   = 1'b1;
      bubble_w_c  = 1'b1;
      kill_hold_d = kill_pend;
    end else if (hz.branch_taken_E) begin
      flush_d_c   = 1'b1;
      flush_e_c   = 1'b1;
      redirect_c  = 1'b1;
      ack_c       = hz.imem_ready;
      kill_hold_d = ~hz.imem_ready;
    end else if (hz.load_use_flag) begin
      stall_f_c   = 1'b1;
      stall_d_c   = 1'b1;
      flush_e_c   = 1'b1;
    end else if (kill_pend & hz.imem_ready) begin
      flush_d_c   = 1'b1;
      stall_f_c   = 1'b1;
      ack_c       = 1'b1;
    end else if (!hz.imem_ready) begin
      stall_f_c   = 1'b1;
      flush_d_c   = 1'b1;
    end else begin
      ack_c       = hz.imem_ready;
    end

    state_d = hz_next_state(mem_wait, kill_hold_d, hz.imem_ready);
  end

  // Controller state; reset abandons any wait or pending wrong-path fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      kill_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_hold_q <= kill_hold_d;
    end
  end

  hazard_wait_timer #(
    .DMEM_TIMEOUT (DMEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_wait (mem_wait),
    .timeout  (timeout_flag)
  );

  // Outputs are held low for as long as reset is asserted.
  assign hz.stall_F        = rst_n & stall_f_c;
  assign hz.stall_D        = rst_n & stall_d_c;
  assign hz.stall_E        = rst_n & stall_e_c;
  assign hz.stall_M        = rst_n & stall_m_c;
  assign hz.flush_D        = rst_n & flush_d_c;
  assign hz.flush_E        = rst_n & flush_e_c;
  assign hz.bubble_W       = rst_n & bubble_w_c;
  assign hz.redirect_valid = rst_n & redirect_c;
  assign hz.imem_ack       = rst_n & ack_c;
  assign hz.dmem_timeout   = rst_n & timeout_flag;

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_WIDTH-1:0] perf_flush_q, perf_flush_d;
  logic                 any_stall, any_flush;

  assign any_stall = stall_f_c | stall_d_c | stall_e_c | stall_m_c;
  assign any_flush = flush_d_c | flush_e_c;

  // Saturating event counters for stall cycles and flush cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (any_stall && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + CNT_WIDTH'(1);
    end
    if (any_flush && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + CNT_WIDTH'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a rule-table reference model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 32;

  // Rule indices in priority order and the control pattern each one produces,
  // packed as {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
  //            bubble_W, redirect_valid, imem_ack}. Rules whose ack follows
  // imem_ready have that bit ORed in afterwards.
  localparam int R_MEMWAIT = 0;
  localparam int R_BRANCH  = 1;
  localparam int R_LOADUSE = 2;
  localparam int R_KILLDROP = 3;
  localparam int R_FETCH   = 4;
  localparam int R_RUN     = 5;
  localparam logic [8:0] RULE_PAT [6] = '{
    9'b111100100,
    9'b000011010,
    9'b110001000,
    9'b100010001,
    9'b100010000,
    9'b000000000
  };

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_WIDTH(CW)) hz ();

  hazard_ctrl #(
    .DMEM_TIMEOUT (TIMEOUT),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int checks = 0;
  int errors = 0;

  bit         m_kill;
  int         m_wd;
  bit         m_to;
  longint     m_stall;
  longint     m_flush;
  int         e_rule;
  bit         e_next_kill;
  logic [8:0] e_ctl;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [8:0] getCtl();
    return {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M, hz.flush_D,
            hz.flush_E, hz.bubble_W, hz.redirect_valid, hz.imem_ack};
  endfunction

  task automatic resetModel();
    m_kill  = 1'b0;
    m_wd    = 0;
    m_to    = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, then check outputs against the model.
  task automatic applyStimulus(input logic lu, input logic br, input logic mo,
                               input logic dr, input logic ir);
    @(negedge clk);
    hz.load_use_flag  = lu;
    hz.branch_taken_E = br;
    hz.mem_op_M       = mo;
    hz.dmem_ready     = dr;
    hz.imem_ready     = ir;
    #1;
    if (!rst_n) resetModel();

    if (mo && !dr)         e_rule = R_MEMWAIT;
    else if (br)           e_rule = R_BRANCH;
    else if (lu)           e_rule = R_LOADUSE;
    else if (m_kill && ir) e_rule = R_KILLDROP;
    else if (!ir)          e_rule = R_FETCH;
    else                   e_rule = R_RUN;

    e_ctl = RULE_PAT[e_rule];
    if (e_rule == R_BRANCH || e_rule == R_RUN) e_ctl[0] = ir;

    case (e_rule)
      R_MEMWAIT: e_next_kill = m_kill;
      R_BRANCH:  e_next_kill = !ir;
      default:   e_next_kill = m_kill && !ir;
    endcase

    if (!rst_n) e_ctl = '0;

    checkOutput("ctl", 64'(getCtl()), 64'(e_ctl));
    checkOutput("timeout", 64'(hz.dmem_timeout), 64'(m_to));
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stall", 64'(hz.perf_stall_cycles), 64'(m_stall));
    checkOutput("perf_flush", 64'(hz.perf_flush_count), 64'(m_flush));
`endif
  endtask

  // Advance the model across the rising edge.
  task automatic stepClock();
    @(posedge clk);
    if (!rst_n) begin
      resetModel();
    end else begin
      if (e_rule == R_MEMWAIT) begin
        m_wd = (m_wd < TIMEOUT) ? m_wd + 1 : TIMEOUT;
        if (m_wd >= TIMEOUT) m_to = 1'b1;
      end else begin
        m_wd = 0;
      end
      m_kill = e_next_kill;
      if (e_rule inside {R_MEMWAIT, R_LOADUSE, R_KILLDROP, R_FETCH}) m_stall++;
      if (e_rule inside {R_BRANCH, R_LOADUSE, R_KILLDROP, R_FETCH})  m_flush++;
    end
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_ctl", 64'(getCtl()), 64'd0);
    checkOutput("rst_timeout", 64'(hz.dmem_timeout), 64'd0);
    stepClock();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n             = 1'b0;
    hz.load_use_flag  = 1'b0;
    hz.branch_taken_E = 1'b0;
    hz.mem_op_M       = 1'b0;
    hz.dmem_ready     = 1'b1;
    hz.imem_ready     = 1'b1;
    resetModel();
    e_rule      = R_RUN;
    e_next_kill = 1'b0;

    pulseReset();

    // Single-cycle load-use hazard.
    applyStimulus(0, 0, 0, 1, 1); stepClock();
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("lu_ctl", 64'(getCtl()), 64'h188);
    stepClock();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("lu_release", 64'(getCtl()), 64'h001);
    stepClock();

    // Three-cycle data-memory wait.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("mw_ctl", 64'(getCtl()), 64'h1E4);
      stepClock();
    end
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("mw_release", 64'(getCtl()), 64'h001);
    stepClock();

    // Taken branch with fetch outstanding, then the wrong-path response is dropped.
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("br_ctl", 64'(getCtl()), 64'h01A);
    stepClock();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("kill_wait", 64'(getCtl()), 64'h110);
    stepClock();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("kill_drop", 64'(getCtl()), 64'h111);
    stepClock();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("kill_done", 64'(getCtl()), 64'h001);
    stepClock();

    // Branch beats load-use in the same cycle.
    applyStimulus(1, 1, 0, 1, 1);
    checkOutput("br_lu", 64'(getCtl()), 64'h01B);
    stepClock();

    // Load-use beats fetch-wait.
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("lu_fetch", 64'(getCtl()), 64'h188);
    stepClock();

    // Broken waits must not trip the watchdog.
    pulseReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 1, (i == 3), 1);
      stepClock();
    end
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("wd_nonconsec", 64'(hz.dmem_timeout), 64'd0);
    stepClock();

    // Four consecutive waits trip the watchdog; it stays set until reset.
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("wd_early", 64'(hz.dmem_timeout), 64'd0);
      stepClock();
    end
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("wd_set", 64'(hz.dmem_timeout), 64'd1);
    stepClock();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("wd_sticky", 64'(hz.dmem_timeout), 64'd1);
    stepClock();
    pulseReset();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("wd_cleared", 64'(hz.dmem_timeout), 64'd0);
    stepClock();

    // Reset while a wrong-path fetch is pending abandons it.
    applyStimulus(0, 1, 0, 1, 0); stepClock();
    pulseReset();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("post_rst_ack", 64'(getCtl()), 64'h001);
    stepClock();

    // Randomized traffic with occasional long memory waits and resets.
    for (int n = 0; n < 3000; n++) begin
      logic lu, br, mo, dr, ir;
      if ($urandom_range(0, 299) == 0) pulseReset();
      lu = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 5) == 0);
      mo = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 1) == 0);
      ir = ($urandom_range(0, 2) != 0);
      if (m_wd > 0 && $urandom_range(0, 3) != 0) begin
        mo = 1'b1;
        dr = 1'b0;
      end
      applyStimulus(lu, br, mo, dr, ir);
      stepClock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit of the 5-stage RISC-V core; consumes the load-use flag from forwarding detection, the EX-stage branch outcome and the instruction/data memory ready handshakes, and drives per-stage stall/flush enables, PC redirect and instruction-response acknowledge. Tracks multi-cycle memory waits and wrong-path fetch responses in a small FSM, with a data-memory watchdog.

## Interface
- DMEM_TIMEOUT, 255: consecutive MEM_WAIT cycles before `dmem_timeout` sets (1..65535).
- CNT_WIDTH, 32: width of the performance counters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load_use_flag  in  1  load-use hazard between D and E
- branch_taken_E  in  1  branch/jal/jalr in EX resolved taken
- mem_op_M  in  1  memread or memwrite in MEM
- dmem_ready  in  1  data access completes this cycle
- imem_ready  in  1  fetch response valid; held until acknowledged
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold the stage's pipeline register
- flush_D, flush_E  out  1 each  load a NOP into IF/ID, ID/EX
- bubble_W  out  1  load a NOP into MEM/WB
- redirect_valid  out  1  PC selects branch target
- imem_ack  out  1  fetch response consumed this cycle
- dmem_timeout  out  1  sticky watchdog error

## Operation
- mem_wait = mem_op_M & ~dmem_ready. Priority: mem_wait > branch > load-use > kill-drop > fetch-wait > run.
- mem_wait: stall_F/D/E/M=1, bubble_W=1; flush_D/E=0, redirect_valid=0, imem_ack=0.
- branch (branch_taken_E & ~mem_wait): flush_D=1, flush_E=1, redirect_valid=1, stall_F=0; load_use_flag ignored; imem_ack=imem_ready.
- load-use: stall_F=1, stall_D=1, flush_E=1, imem_ack=0.
- kill-drop (kill_pend & imem_ready): flush_D=1, stall_F=1, imem_ack=1 (wrong-path response discarded).
- fetch-wait (~imem_ready): stall_F=1, flush_D=1, imem_ack=0.
- run: all stalls/flushes 0, imem_ack=imem_ready.
- kill_pend next: branch case -> ~imem_ready; mem_wait -> hold; else kill_pend & ~imem_ready.
- FSM states RUN, MEM_WAIT, FETCH_WAIT, KILL, encoded from the winning case's next-cycle view: mem_wait -> MEM_WAIT; kill_pend next=1 -> KILL; ~imem_ready -> FETCH_WAIT; else RUN.
- Watchdog: counter increments each mem_wait cycle, clears on any non-mem_wait cycle, saturates at DMEM_TIMEOUT; reaching it sets dmem_timeout, cleared only by reset. Pipeline behaviour unaffected.

## Timing
- All stall/flush/redirect/ack outputs combinational from inputs and registered state; zero-cycle latency.
- State, kill_pend, watchdog, counters update on rising clk.
- Reset: state RUN, kill_pend 0, watchdog 0, dmem_timeout 0, counters 0; while rst_n low every output forced 0.
- Reset mid-wait or mid-kill abandons it; first post-reset cycle behaves as RUN.
- Branch with kill_pend already set and imem_ready=1: response dropped by flush_D, kill_pend cleared.
- Branch during mem_wait: no action; E is held so branch_taken_E re-presents after the wait.
- Load-use with ~imem_ready: load-use wins (stall_D=1, flush_E=1, flush_D=0).

## Configuration
- HAZARD_PERF_EN defined: adds outputs perf_stall_cycles (CNT_WIDTH, +1 each cycle any stall_* high) and perf_flush_count (+1 each cycle flush_D or flush_E high); both saturate at all-ones, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package hazard_pkg: state enum (RUN, MEM_WAIT, FETCH_WAIT, KILL), opcode constants for NOP injection.
- One sub-module hazard_wait_timer: watchdog counter plus sticky flag, parameterised by DMEM_TIMEOUT.

## Test plan
- load_use_flag=1 one cycle, memories ready -> stall_F=stall_D=flush_E=1 that cycle only; state RUN.
- mem_op_M=1, dmem_ready low 3 cycles -> stall_F/D/E/M=1, bubble_W=1 for 3 cycles, state MEM_WAIT, released cycle 4.
- branch_taken_E=1 with imem_ready=0 -> redirect_valid=1, flush_D/E=1, next state KILL; imem_ready=1 two cycles later -> flush_D=1, imem_ack=1, stall_F=1, then RUN.
- branch_taken_E=1 and load_use_flag=1 same cycle -> branch wins: stall_D=0, flush_D=flush_E=1.
- DMEM_TIMEOUT=4, dmem_ready low 4 cycles -> dmem_timeout rises after 4th, stays high after dmem_ready; clears only on rst_n.
- rst_n low during KILL -> all outputs 0, kill_pend 0; after release imem_ready=1 -> imem_ack=1, flush_D=0.
